fft_mem_sequencer: RTL

Top-level frame sequencer for the FFT memory subsystem. Drives the select inputs of the ping-pong memory mux through receive, FFT stage, and transmit phases, and hands a per-stage start/done handshake to the butterfly engine. Sits between the AXIS slave/master adapters, the FFT stage engine and the memory mux. Guarantees the final stage always writes mem0, the only bank readable by the AXIS transmit path.

---
 rtl/fft_mem_sequencer_pkg.sv | 50 +++++
 rtl/fft_mem_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fft_mem_sequencer_pkg.sv
// Shared types for the FFT frame sequencer: state encoding, registered select bundle
// and the decode from a state to the mux selects it owns.
package fft_mem_sequencer_pkg;

   localparam int FFT_NUM_STAGES = 12;
   localparam int SEQ_CNT_W      = 16;

   typedef enum logic [2:0] {
      SEQ_IDLE      = 3'd0,
      SEQ_RX        = 3'd1,
      SEQ_STG_SETUP = 3'd2,
      SEQ_STG_RUN   = 3'd3,
      SEQ_TX        = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic axis_rx;
      logic axis_tx;
      logic rmem_id;
      logic wmem_id;
      logic busy;
   } seq_sel_t;

   localparam seq_sel_t SEQ_SEL_RESET = '{axis_rx: 1'b0, axis_tx: 1'b0, rmem_id: 1'b0,
                                          wmem_id: 1'b1, busy: 1'b0};

   // Outside the FFT stages the engine reads mem0 and writes mem1, so it can never
   // corrupt mem0 while an AXIS adapter owns it.
   function automatic seq_sel_t seq_decode(input seq_state_e st, input logic stage_lsb);
      seq_sel_t sel;
      sel      = SEQ_SEL_RESET;
      sel.busy = 1'b1;
      unique case (st)
         SEQ_IDLE:                   sel.busy    = 1'b0;
         SEQ_RX:                     sel.axis_rx = 1'b1;
         SEQ_STG_SETUP, SEQ_STG_RUN: begin
            sel.rmem_id = stage_lsb;
            sel.wmem_id = ~stage_lsb;
         end
         SEQ_TX:                     sel.axis_tx = 1'b1;
         default:                    sel.busy    = 1'b0;
      endcase
      return sel;
   endfunction

   function automatic logic seq_counts(input seq_state_e st);
      return (st == SEQ_RX) || (st == SEQ_STG_RUN) || (st == SEQ_TX);
   endfunction

endpackage

// File: rtl/fft_mem_sequencer.sv
// Frame sequencer for the ping-pong FFT memory: RX -> NUM_STAGES x (setup, run) -> TX.
// Optional per-phase watchdog enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_mem_sequencer
   import fft_mem_sequencer_pkg::*;
#(
   parameter int FFT_SIZE    = 4096,
   parameter int NUM_STAGES  = FFT_NUM_STAGES,
   parameter int STAGE_W     = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               rx_frame_done,
   input  logic               stage_done,
   input  logic               tx_frame_done,
   output logic               axis_rx,
   output logic               axis_tx,
   output logic               rmem_id,
   output logic               wmem_id,
   output logic               stage_start,
   output logic [STAGE_W-1:0] stage_idx,
   output logic               busy,
   output logic               frame_done,
   output logic               timeout_err
);

   if ((NUM_STAGES % 2) != 0 || NUM_STAGES < 2) begin : g_bad_stages
      $error("fft_mem_sequencer: NUM_STAGES must be even so the last stage writes mem0");
   end
   if ((1 << STAGE_W) < NUM_STAGES) begin : g_bad_stage_w
      $error("fft_mem_sequencer: STAGE_W too narrow for NUM_STAGES");
   end
   if (FFT_SIZE < 2 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_size
      $error("fft_mem_sequencer: FFT_SIZE must be a power of two");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << SEQ_CNT_W)) begin : g_bad_timeout
      $error("fft_mem_sequencer: TIMEOUT_CYC must fit the 16-bit watchdog");
   end

   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

   seq_state_e         state_q, state_d, phase_d;
   logic [STAGE_W-1:0] stage_idx_q, stage_idx_d;
   seq_sel_t           sel_q;
   logic               stage_start_q;
   logic               frame_done_q, frame_done_d;
   logic               timeout_fire;

   always_comb begin
      phase_d      = state_q;
      stage_idx_d  = stage_idx_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         SEQ_IDLE: begin
            if (start) phase_d = SEQ_RX;
         end
         SEQ_RX: begin
            if (rx_frame_done) begin
               phase_d     = SEQ_STG_SETUP;
               stage_idx_d = '0;
            end
         end
         SEQ_STG_SETUP: begin
            phase_d = SEQ_STG_RUN;
         end
         SEQ_STG_RUN: begin
            if (stage_done) begin
               if (stage_idx_q == LAST_STAGE) begin
                  phase_d = SEQ_TX;
               end else begin
                  phase_d     = SEQ_STG_SETUP;
                  stage_idx_d = stage_idx_q + STAGE_W'(1);
               end
            end
         end
         SEQ_TX: begin
            if (tx_frame_done) begin
               phase_d      = SEQ_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: phase_d = SEQ_IDLE;
      endcase
      state_d = timeout_fire ? SEQ_IDLE : phase_d;
   end

   // Selects are registered from the next state so they settle on STG_SETUP entry;
   // stage_start fires one cycle later, in the first STG_RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SEQ_IDLE;
         stage_idx_q   <= '0;
         sel_q         <= SEQ_SEL_RESET;
         stage_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         stage_idx_q   <= stage_idx_d;
         sel_q         <= seq_decode(state_d, stage_idx_d[0]);
         stage_start_q <= (state_q == SEQ_STG_SETUP);
         frame_done_q  <= frame_done_d;
      end
   end

`ifdef FFT_SEQ_TIMEOUT_EN
   logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;
   logic                 timeout_err_q, timeout_err_d;

   // The watchdog only fires when no legitimate transition is already taking place.
   assign timeout_fire = seq_counts(state_q) && (cnt_q == SEQ_CNT_W'(TIMEOUT_CYC - 1)) &&
                         (phase_d == state_q);

   always_comb begin
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (seq_counts(state_q)) begin
         cnt_d = cnt_q + SEQ_CNT_W'(1);
      end
      if (state_q == SEQ_IDLE && start) begin
         timeout_err_d = 1'b0;
      end
      if (timeout_fire) begin
         timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_fire = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   assign axis_rx     = sel_q.axis_rx;
   assign axis_tx     = sel_q.axis_tx;
   assign rmem_id     = sel_q.rmem_id;
   assign wmem_id     = sel_q.wmem_id;
   assign busy        = sel_q.busy;
   assign stage_start = stage_start_q;
   assign stage_idx   = stage_idx_q;
   assign frame_done  = frame_done_q;

endmodule
